// File: rtl/display_scan_if.sv
// Digit/display bundle between the BCD counter stage and the scan driver.
// The counter side is the master; display_scan is the slave.
interface display_scan_if;
  logic       Blank_lz;
  logic [3:0] bcd_h_1;
  logic [3:0] bcd_h_0;
  logic [3:0] bcd_min_1;
  logic [3:0] bcd_min_0;
  logic [3:0] bcd_s_1;
  logic [3:0] bcd_s_0;
  logic [3:0] bcd_ms_2;
  logic [3:0] bcd_ms_1;
  logic [3:0] bcd_ms_0;
  logic [6:0] seg;
  logic       dp;
  logic [8:0] an;
  logic       frame;

  modport master (
    output Blank_lz, bcd_h_1, bcd_h_0, bcd_min_1, bcd_min_0,
           bcd_s_1, bcd_s_0, bcd_ms_2, bcd_ms_1, bcd_ms_0,
    input  seg, dp, an, frame
  );

  modport slave (
    input  Blank_lz, bcd_h_1, bcd_h_0, bcd_min_1, bcd_min_0,
           bcd_s_1, bcd_s_0, bcd_ms_2, bcd_ms_1, bcd_ms_0,
    output seg, dp, an, frame
  );
endinterface

// File: rtl/display_scan.sv
// Time-multiplexed 9-digit 7-segment scanner with per-frame tear-free snapshot,
// separator decimal points and optional hours leading-zero blanking. Falling-edge clocked.
module display_scan #(
  parameter int unsigned DIV = 1000
) (
  input logic         NEclk,
  input logic         Nreset,
  display_scan_if.slave dsp
);
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(DIV - 1);

  logic [PW-1:0]    presc_q;
  logic [3:0]       idx_q;
  logic             first_q;
  logic [8:0][3:0]  shadow_q;
  logic [8:0][3:0]  digits;
  logic             tick, wrap, snap;

  logic [3:0]       cur;
  logic             blank;
  logic [6:0]       seg_d, seg_q;
  logic             dp_d, dp_q;
  logic [8:0]       an_d, an_q;
  logic             frame_q;

  // Index 8 is the leftmost digit (hours tens), index 0 is ms units.
  assign digits = {dsp.bcd_h_1, dsp.bcd_h_0, dsp.bcd_min_1, dsp.bcd_min_0,
                   dsp.bcd_s_1, dsp.bcd_s_0, dsp.bcd_ms_2, dsp.bcd_ms_1, dsp.bcd_ms_0};

  assign tick = (presc_q == PrescLast);
  assign wrap = tick && (idx_q == 4'd8);
  assign snap = wrap || first_q;

  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      presc_q  <= '0;
      idx_q    <= '0;
      first_q  <= 1'b1;
      shadow_q <= '0;
      frame_q  <= 1'b0;
      an_q     <= '0;
      seg_q    <= '0;
      dp_q     <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        idx_q <= wrap ? 4'd0 : idx_q + 4'd1;
      end
      first_q <= 1'b0;
      frame_q <= snap;
      if (snap) begin
        shadow_q <= digits;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  always_comb begin
    cur   = shadow_q[idx_q];
    blank = dsp.Blank_lz &&
            (((idx_q == 4'd8) && (shadow_q[8] == 4'd0)) ||
             ((idx_q == 4'd7) && (shadow_q[8] == 4'd0) && (shadow_q[7] == 4'd0)));
    case (cur)
      4'd0:    seg_d = 7'b0111111;
      4'd1:    seg_d = 7'b0000110;
      4'd2:    seg_d = 7'b1011011;
      4'd3:    seg_d = 7'b1001111;
      4'd4:    seg_d = 7'b1100110;
      4'd5:    seg_d = 7'b1101101;
      4'd6:    seg_d = 7'b1111101;
      4'd7:    seg_d = 7'b0000111;
      4'd8:    seg_d = 7'b1111111;
      4'd9:    seg_d = 7'b1101111;
      default: seg_d = 7'b1000000;
    endcase
    an_d = 9'd1 << idx_q;
    dp_d = ((idx_q == 4'd3) || (idx_q == 4'd5) || (idx_q == 4'd7)) && !blank;
    if (blank) begin
      seg_d = '0;
    end
    // Shadows are only valid after the start-up snapshot edge, so stay dark on it.
    if (first_q) begin
      an_d  = '0;
      seg_d = '0;
      dp_d  = 1'b0;
    end
  end

  assign dsp.an    = an_q;
  assign dsp.seg   = seg_q;
  assign dsp.dp    = dp_q;
  assign dsp.frame = frame_q;
endmodule
